// File: rtl/ahb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_cmd_master
//  Description : Single-transfer AHB initiator. Turns a valid/ready command
//                stream into AHB SINGLE NONSEQ reads/writes and returns one
//                registered response per command. One address-phase slot (A)
//                and one data-phase slot (D) let address and data phases of
//                consecutive commands overlap.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_cmd_master #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  // command stream
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response stream
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  // AHB master interface
  output logic                  hsel,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [3:0]            hprot,
  output logic [2:0]            hsize,
  output logic [1:0]            htrans,
  output logic [2:0]            hburst,
  output logic                  hwrite,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic [1:0]            hresp,
  input  logic                  hready,
  input  logic                  hgrant,
  input  logic [DATA_WIDTH-1:0] hrdata
);

  localparam logic [1:0] c_htrans_idle   = 2'b00;
  localparam logic [1:0] c_htrans_nonseq = 2'b10;
  localparam logic [1:0] c_hresp_error   = 2'b01;
  localparam logic [2:0] c_hsize_idle    = 3'b010;
  localparam logic [2:0] c_hburst_single = 3'b000;

  // Address-phase slot
  logic                  r_a_pend;
  logic                  r_a_write;
  logic [2:0]            r_a_size;
  logic [ADDR_WIDTH-1:0] r_a_addr;
  logic [DATA_WIDTH-1:0] r_a_wdata;

  // Data-phase slot
  logic                  r_d_pend;
  logic                  r_d_write;
  logic [DATA_WIDTH-1:0] r_d_wdata;

  // Registered response
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic w_err_cancel;
  logic w_a_issue;
  logic w_a_done;
  logic w_d_done;
  logic w_accept;

  // First ERROR cycle: the slave wants the following transfer withdrawn,
  // so the queued address phase is suppressed for exactly this cycle.
  assign w_err_cancel = r_d_pend && (hresp == c_hresp_error) && !hready;
  assign w_a_issue    = r_a_pend && hgrant && !w_err_cancel;
  assign w_a_done     = w_a_issue && hready;
  assign w_d_done     = r_d_pend && hready;

  // The A slot frees up in the same cycle its address phase completes,
  // which is what allows one command per cycle at zero wait states.
  assign cmd_ready = !r_a_pend || w_a_done;
  assign w_accept  = cmd_valid && cmd_ready;

  assign htrans = w_a_issue ? c_htrans_nonseq : c_htrans_idle;
  assign hsel   = w_a_issue;
  assign haddr  = r_a_addr;
  assign hwrite = r_a_write;
  assign hsize  = r_a_size;
  assign hwdata = r_d_wdata;
  assign hprot  = HPROT_VAL;
  assign hburst = c_hburst_single;
  assign busy   = r_a_pend || r_d_pend;

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

  // A slot: load on accept, return to idle bus values once issued.
  // cmd_size is passed through unchanged; sizes wider than the data bus are
  // the requester's responsibility.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_a_pend  <= 1'b0;
      r_a_write <= 1'b0;
      r_a_size  <= c_hsize_idle;
      r_a_addr  <= '0;
      r_a_wdata <= '0;
    end else if (w_accept) begin
      r_a_pend  <= 1'b1;
      r_a_write <= cmd_write;
      r_a_size  <= cmd_size;
      r_a_addr  <= cmd_addr;
      r_a_wdata <= cmd_wdata;
    end else if (w_a_done) begin
      r_a_pend  <= 1'b0;
      r_a_write <= 1'b0;
      r_a_size  <= c_hsize_idle;
      r_a_addr  <= '0;
      r_a_wdata <= '0;
    end
  end

  // D slot: take over from A when its address phase completes, else clear
  // when the data phase finishes so hwdata idles at zero.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_d_pend  <= 1'b0;
      r_d_write <= 1'b0;
      r_d_wdata <= '0;
    end else if (w_a_done) begin
      r_d_pend  <= 1'b1;
      r_d_write <= r_a_write;
      r_d_wdata <= r_a_wdata;
    end else if (w_d_done) begin
      r_d_pend  <= 1'b0;
      r_d_write <= 1'b0;
      r_d_wdata <= '0;
    end
  end

  // Response: one-cycle pulse the cycle after the data phase completes.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_d_done;
      r_rsp_err   <= w_d_done && (hresp == c_hresp_error);
      r_rsp_rdata <= (w_d_done && !r_d_write) ? hrdata : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_cmd_master
//  Description : Directed bench for ahb_cmd_master with a queue-based
//                transaction model checked every cycle, plus literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_cmd_master;

  logic        hclk;
  logic        hresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        hsel;
  logic [31:0] haddr;
  logic [3:0]  hprot;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [1:0]  hresp;
  logic        hready;
  logic        hgrant;
  logic [31:0] hrdata;

  ahb_cmd_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .HPROT_VAL (4'b0011)
  ) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_size (cmd_size),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .hsel     (hsel),
    .haddr    (haddr),
    .hprot    (hprot),
    .hsize    (hsize),
    .htrans   (htrans),
    .hburst   (hburst),
    .hwrite   (hwrite),
    .hwdata   (hwdata),
    .hresp    (hresp),
    .hready   (hready),
    .hgrant   (hgrant),
    .hrdata   (hrdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int n_vec = 0;
  int n_err = 0;
  int rsp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic        w;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
  } cmd_t;

  cmd_t        aq[$];   // accepted, address phase not yet completed
  cmd_t        dq[$];   // in data phase
  cmd_t        m_c;
  logic        m_rv, m_re;
  logic [31:0] m_rd;
  logic        m_cancel, m_issue, m_ready;

  always @(negedge hclk) begin
    if (!hresetn) begin
      aq.delete();
      dq.delete();
      m_rv = 1'b0; m_re = 1'b0; m_rd = '0;
      chk("rst_htrans", {30'd0, htrans}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end else begin
      m_cancel = (dq.size() != 0) && (hresp == 2'b01) && !hready;
      m_issue  = (aq.size() != 0) && hgrant && !m_cancel;
      m_ready  = (aq.size() == 0) || (m_issue && hready);

      chk("htrans", {30'd0, htrans}, m_issue ? 32'd2 : 32'd0);
      chk("hsel", {31'd0, hsel}, {31'd0, m_issue});
      chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_ready});
      chk("busy", {31'd0, busy}, {31'd0, (aq.size() != 0) || (dq.size() != 0)});
      chk("hburst", {29'd0, hburst}, 32'd0);
      chk("hprot", {28'd0, hprot}, 32'd3);
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rv});
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_re});
      chk("rsp_rdata", rsp_rdata, m_rd);
      if (aq.size() != 0) begin
        chk("haddr", haddr, aq[0].a);
        chk("hwrite", {31'd0, hwrite}, {31'd0, aq[0].w});
        chk("hsize", {29'd0, hsize}, {29'd0, aq[0].sz});
      end else begin
        chk("haddr_idle", haddr, 32'd0);
        chk("hwrite_idle", {31'd0, hwrite}, 32'd0);
        chk("hsize_idle", {29'd0, hsize}, 32'd2);
      end
      if (dq.size() != 0) chk("hwdata", hwdata, dq[0].wd);
      else                chk("hwdata_idle", hwdata, 32'd0);

      if (rsp_valid) rsp_cnt++;

      // outcome of the coming clock edge
      if ((dq.size() != 0) && hready) begin
        m_rv = 1'b1;
        m_re = (hresp == 2'b01);
        m_rd = dq[0].w ? 32'd0 : hrdata;
        void'(dq.pop_front());
      end else begin
        m_rv = 1'b0; m_re = 1'b0; m_rd = '0;
      end
      if (m_issue && hready) dq.push_back(aq.pop_front());
      if (cmd_valid && m_ready) begin
        m_c.w = cmd_write; m_c.sz = cmd_size; m_c.a = cmd_addr; m_c.wd = cmd_wdata;
        aq.push_back(m_c);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_size = 3'b010;
  endtask

  initial begin
    hresetn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 3'b010; cmd_addr = '0; cmd_wdata = '0;
    hresp = 2'b00; hready = 1'b1; hgrant = 1'b1; hrdata = '0;

    // reset state
    tick(); tick(); #2;
    chk("r_htrans", {30'd0, htrans}, 32'd0);
    chk("r_hsel", {31'd0, hsel}, 32'd0);
    chk("r_haddr", haddr, 32'd0);
    chk("r_hwrite", {31'd0, hwrite}, 32'd0);
    chk("r_hwdata", hwdata, 32'd0);
    chk("r_hsize", {29'd0, hsize}, 32'd2);
    chk("r_hburst", {29'd0, hburst}, 32'd0);
    chk("r_hprot", {28'd0, hprot}, 32'd3);
    chk("r_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    chk("r_rdata", rsp_rdata, 32'd0);
    chk("r_busy", {31'd0, busy}, 32'd0);
    chk("r_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick(); hresetn = 1'b1;

    // single write
    tick(); cmd(1'b1, 32'h4000_0010, 32'h2000_0000); #2 chk("t1_ready", {31'd0, cmd_ready}, 32'd1);
    tick(); cmd_valid = 1'b0; #2;
    chk("t1_htrans", {30'd0, htrans}, 32'd2);
    chk("t1_hwrite", {31'd0, hwrite}, 32'd1);
    chk("t1_haddr", haddr, 32'h4000_0010);
    tick(); #2 chk("t1_hwdata", hwdata, 32'h2000_0000);
    tick(); #2 chk("t1_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
    tick(); #2 chk("t1_busy", {31'd0, busy}, 32'd0);

    // read with two wait states, second command queued behind it
    tick(); cmd(1'b0, 32'h4000_0008, 32'h5555_0000);
    tick(); cmd(1'b1, 32'h4000_0020, 32'h1111_1111); #2 chk("t2_haddr0", haddr, 32'h4000_0008);
    tick(); cmd_valid = 1'b0; hready = 1'b0; #2;
    chk("t2_ready_w1", {31'd0, cmd_ready}, 32'd0);
    chk("t2_hwdata_w1", hwdata, 32'h5555_0000);
    chk("t2_haddr_w1", haddr, 32'h4000_0020);
    tick(); #2;
    chk("t2_ready_w2", {31'd0, cmd_ready}, 32'd0);
    chk("t2_hwdata_w2", hwdata, 32'h5555_0000);
    chk("t2_haddr_w2", haddr, 32'h4000_0020);
    tick(); hready = 1'b1; hrdata = 32'hDEAD_BEEF; #2 chk("t2_ready_go", {31'd0, cmd_ready}, 32'd1);
    tick(); hrdata = '0; #2;
    chk("t2_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
    chk("t2_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("t2_hwdata2", hwdata, 32'h1111_1111);
    tick(); #2 chk("t2_rsp2", {30'd0, rsp_valid, rsp_err}, 32'd2);
    tick();

    // back-to-back pipelining
    tick(); cmd(1'b1, 32'h0000_0000, 32'h0000_00A0); #2 chk("t3_ready0", {31'd0, cmd_ready}, 32'd1);
    tick(); cmd(1'b1, 32'h0000_0004, 32'h0000_00A1); #2 chk("t3_ready1", {31'd0, cmd_ready}, 32'd1);
    chk("t3_ns0", {30'd0, htrans}, 32'd2);
    tick(); cmd(1'b1, 32'h0000_0010, 32'h0000_00A2); #2 chk("t3_ready2", {31'd0, cmd_ready}, 32'd1);
    chk("t3_ns1", {30'd0, htrans}, 32'd2);
    tick(); cmd_valid = 1'b0; #2;
    chk("t3_ns2", {30'd0, htrans}, 32'd2);
    chk("t3_addr2", haddr, 32'h0000_0010);
    chk("t3_rsp0", {31'd0, rsp_valid}, 32'd1);
    tick(); #2 chk("t3_rsp1", {31'd0, rsp_valid}, 32'd1);
    chk("t3_wd2", hwdata, 32'h0000_00A2);
    tick(); #2 chk("t3_rsp2", {31'd0, rsp_valid}, 32'd1);
    tick(); #2 chk("t3_rsp_end", {31'd0, rsp_valid}, 32'd0);

    // grant stall
    tick(); hgrant = 1'b0; cmd(1'b0, 32'h4000_0030, 32'h0);
    tick(); cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) tick();
      #2;
      chk("t4_stall_trans", {30'd0, htrans}, 32'd0);
      chk("t4_stall_hsel", {31'd0, hsel}, 32'd0);
    end
    tick(); hgrant = 1'b1; #2 chk("t4_ns", {30'd0, htrans}, 32'd2);
    tick(); hrdata = 32'h1234_5678;
    tick(); hrdata = '0; #2 chk("t4_rdata", rsp_rdata, 32'h1234_5678);
    tick();

    // ERROR cancel with a queued second write
    tick(); cmd(1'b1, 32'h0000_0050, 32'h0000_00AA);
    tick(); cmd(1'b1, 32'h0000_0054, 32'h0000_00BB);
    tick(); cmd_valid = 1'b0; hresp = 2'b01; hready = 1'b0; #2;
    chk("t5_cancel", {30'd0, htrans}, 32'd0);
    chk("t5_ready", {31'd0, cmd_ready}, 32'd0);
    tick(); hready = 1'b1; #2;
    chk("t5_reissue", {30'd0, htrans}, 32'd2);
    chk("t5_addrB", haddr, 32'h0000_0054);
    tick(); hresp = 2'b00; #2 chk("t5_rspA", {30'd0, rsp_valid, rsp_err}, 32'd3);
    tick(); #2 chk("t5_rspB", {30'd0, rsp_valid, rsp_err}, 32'd2);
    tick();

    // single-cycle ERROR with hready high
    tick(); cmd(1'b1, 32'h0000_0058, 32'h0000_00CC);
    tick(); cmd_valid = 1'b0;
    tick(); hresp = 2'b01;
    tick(); hresp = 2'b00; #2 chk("t5b_rsp", {30'd0, rsp_valid, rsp_err}, 32'd3);
    tick();

    // reset during a read data phase
    tick(); cmd(1'b0, 32'h0000_0060, 32'h0);
    tick(); cmd_valid = 1'b0;
    tick(); hready = 1'b0; #2 hresetn = 1'b0; #1;
    chk("t6_htrans", {30'd0, htrans}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_rsp", {31'd0, rsp_valid}, 32'd0);
    tick(); hready = 1'b1;
    tick(); hresetn = 1'b1;
    tick(); cmd(1'b1, 32'h0000_0064, 32'h0000_0077);
    tick(); cmd_valid = 1'b0; #2 chk("t6_haddr", haddr, 32'h0000_0064);
    tick(); #2 chk("t6_hwdata", hwdata, 32'h0000_0077);
    tick(); #2 chk("t6_rsp_new", {30'd0, rsp_valid, rsp_err}, 32'd2);
    tick(); tick();

    // every accepted command answered exactly once, except the one lost to reset
    chk("rsp_count", rsp_cnt, 32'd11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_cmd_master.md
Name: ahb_cmd_master

Overview:
- Single-transfer AHB initiator. Converts a valid/ready command stream into AHB SINGLE read and write transfers and returns one response per command.
- Used to drive register-style AHB slave ports from firmware-less control logic, e.g. the IOPMP configuration port loaded at boot, or a DMA/debug path.
- Handles grant, wait states, two-cycle ERROR responses and address/data pipelining.

Parameters:
- ADDR_WIDTH, 32, width of haddr and cmd_addr.
- DATA_WIDTH, 32, width of hwdata/hrdata, cmd_wdata and rsp_rdata.
- HPROT_VAL, 4'b0011, constant hprot driven on every transfer (data access, privileged).

Ports:
- hclk  in  1  clock.
- hresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at the hclk edge.
- cmd_write  in  1  1=write, 0=read.
- cmd_size  in  3  AHB hsize encoding; values above log2(DATA_WIDTH/8) are unsupported.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle pulse per completed command.
- rsp_err  out  1  valid with rsp_valid; 1 = slave returned ERROR.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes); valid with rsp_valid.
- busy  out  1  any command in address or data phase.
- hsel  out  1  AHB select.
- haddr  out  ADDR_WIDTH  AHB address.
- hprot  out  4  AHB protection.
- hsize  out  3  AHB size.
- htrans  out  2  AHB transfer type (IDLE 2'b00 / NONSEQ 2'b10 only).
- hburst  out  3  AHB burst; always SINGLE (3'b000).
- hwrite  out  1  AHB direction.
- hwdata  out  DATA_WIDTH  AHB write data.
- hresp  in  2  OKAY 2'b00, ERROR 2'b01.
- hready  in  1  transfer done / bus ready.
- hgrant  in  1  bus granted to this master.
- hrdata  in  DATA_WIDTH  AHB read data.

Behaviour:
- Reset state (also the idle state): htrans=IDLE, hsel=0, haddr=0, hwrite=0, hwdata=0, hsize=3'b010, hburst=0, hprot=HPROT_VAL, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0. cmd_ready=1 out of reset.
- Slots: A (address-phase slot, one deep) and D (data-phase slot, one deep).
- Command acceptance: cmd_ready = !A_pend | a_done. On accept, A loads addr/write/size/wdata and A_pend=1. haddr/hwrite/hsize are driven from A on the next cycle.
- Address phase:
  - htrans = NONSEQ and hsel=1 when A_pend & hgrant & !err_cancel; otherwise htrans=IDLE and hsel=0. These are combinational on hgrant and hresp.
  - a_done = A_pend & hgrant & hready & !err_cancel.
  - On a_done, A moves into D (D_pend=1, D captures write/wdata). hwdata = D.wdata, stable for the whole data phase.
- Data phase:
  - Completes on the first cycle with D_pend & hready.
  - Next cycle: rsp_valid=1, rsp_err=(hresp==ERROR), rsp_rdata = read ? hrdata : 0.
  - Zero wait states give back-to-back throughput of 1 command/cycle. Latency from accept to rsp_valid is 3 cycles.
- Error handling:
  - err_cancel = D_pend & hresp==ERROR & !hready, i.e. the first ERROR cycle.
  - In that cycle htrans is forced to IDLE. The pending A command is not issued, is retained, and is re-presented from the following cycle.
  - The second ERROR cycle (hready=1) completes D with rsp_err=1.
- hresp==ERROR with hready=1 and no preceding ERROR/!hready cycle is still reported as rsp_err=1.
- hgrant low: A waits and htrans=IDLE. An in-flight D phase still completes independent of hgrant.
- Simultaneous events:
  - A D completion and a_done in the same cycle are legal; the new D loads while rsp_valid pulses for the old one.
  - A new accept is legal in the same cycle.
- busy = A_pend | D_pend.
- Asynchronous reset mid-transfer: all slots are cleared and no response is issued for lost commands. The bus shows htrans=IDLE immediately.
- No response backpressure: the consumer must take rsp_valid every cycle.

Test Plan:
- Single write: cmd write 0x4000_0010 ← 0x2000_0000, hgrant=1, hready=1. Required: NONSEQ/hwrite=1 at haddr 0x4000_0010, hwdata=0x2000_0000 the next cycle, rsp_valid 3 cycles after accept with rsp_err=0.
- Read with 2 wait states: read 0x4000_0008, hready low for 2 data cycles, hrdata=0xDEAD_BEEF on the completing cycle. Required: haddr and hwdata held; rsp_rdata=0xDEAD_BEEF, rsp_err=0; cmd_ready low while A is occupied.
- Back-to-back pipelining: 3 writes to 0x00, 0x04, 0x10 offered continuously with zero wait states. Required: 3 consecutive NONSEQ cycles, 3 consecutive rsp_valid pulses in order, cmd_ready stays 1.
- Grant stall: hgrant=0 for 4 cycles with a command pending. Required: htrans=IDLE and hsel=0 for those cycles; NONSEQ on the first cycle hgrant=1; no response is lost or duplicated.
- ERROR cancel: write A then write B back-to-back; slave returns ERROR/hready=0 then ERROR/hready=1 for A. Required: htrans=IDLE in the first ERROR cycle, rsp for A has rsp_err=1, B is reissued afterwards and completes with rsp_err=0.
- Reset mid-operation: assert hresetn=0 during the data phase of a read. Required: htrans=IDLE, busy=0, rsp_valid=0 immediately; after release, a new command completes normally.
